tri_raster_scan: RTL

Bounding-box scan sequencer for the triangle rasterizer. It accepts one triangle (three 10-bit vertices) per handshake and computes its screen-clipped bounding box. It then walks every pixel of that box in raster order, driving each candidate point plus the vertices to the combinational point-in-triangle test, and consumes that test's `inside` result. Inside pixels are emitted as fragments over a valid/ready interface to the downstream pixel writer.

---
 rtl/tri_raster_scan_if.sv | 39 +++
 rtl/tri_raster_scan.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tri_raster_scan_if.sv
// Handshake/bus bundle for tri_raster_scan: triangle input, inside-test port, fragment output.
// frag_count exists only when TRI_RASTER_STATS_EN is defined.
interface tri_raster_scan_if;
  logic       tri_valid;
  logic       tri_ready;
  logic [9:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic [9:0] test_ptx, test_pty;
  logic [9:0] test_p1x, test_p1y, test_p2x, test_p2y, test_p3x, test_p3y;
  logic       test_inside;
  logic       frag_valid;
  logic       frag_ready;
  logic [9:0] frag_x, frag_y;
  logic       done;
`ifdef TRI_RASTER_STATS_EN
  logic [19:0] frag_count;

  modport master (
    input  tri_valid, v1x, v1y, v2x, v2y, v3x, v3y, test_inside, frag_ready,
    output tri_ready, test_ptx, test_pty, test_p1x, test_p1y, test_p2x, test_p2y,
           test_p3x, test_p3y, frag_valid, frag_x, frag_y, done, frag_count
  );
  modport slave (
    output tri_valid, v1x, v1y, v2x, v2y, v3x, v3y, test_inside, frag_ready,
    input  tri_ready, test_ptx, test_pty, test_p1x, test_p1y, test_p2x, test_p2y,
           test_p3x, test_p3y, frag_valid, frag_x, frag_y, done, frag_count
  );
`else
  modport master (
    input  tri_valid, v1x, v1y, v2x, v2y, v3x, v3y, test_inside, frag_ready,
    output tri_ready, test_ptx, test_pty, test_p1x, test_p1y, test_p2x, test_p2y,
           test_p3x, test_p3y, frag_valid, frag_x, frag_y, done
  );
  modport slave (
    output tri_valid, v1x, v1y, v2x, v2y, v3x, v3y, test_inside, frag_ready,
    input  tri_ready, test_ptx, test_pty, test_p1x, test_p1y, test_p2x, test_p2y,
           test_p3x, test_p3y, frag_valid, frag_x, frag_y, done
  );
`endif
endinterface

// File: rtl/tri_raster_scan.sv
// Bounding-box scan sequencer: walks the screen-clipped box of one triangle in raster order
// and emits inside pixels as fragments. Define TRI_RASTER_STATS_EN to add the frag_count output.
module tri_raster_scan #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic          clk,
  input logic          rst,
  tri_raster_scan_if.master bus
);
  localparam logic [9:0] X_LIM = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_LIM = 10'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [9:0] vx_q [3];
  logic [9:0] vx_d [3];
  logic [9:0] vy_q [3];
  logic [9:0] vy_d [3];
  logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic [9:0] ptx_q, ptx_d, pty_q, pty_d;
  logic [9:0] frag_x_q, frag_x_d, frag_y_q, frag_y_d;
  logic       frag_valid_q, frag_valid_d;
  logic       done_q, done_d;
  logic [9:0] bx_min, bx_max, by_min, by_max;
  logic       off_screen, adv, last_pt;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [9:0] clip(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Bounding box is evaluated from the latched vertices during SETUP.
  assign bx_min     = min3(vx_q[0], vx_q[1], vx_q[2]);
  assign bx_max     = clip(max3(vx_q[0], vx_q[1], vx_q[2]), X_LIM);
  assign by_min     = min3(vy_q[0], vy_q[1], vy_q[2]);
  assign by_max     = clip(max3(vy_q[0], vy_q[1], vy_q[2]), Y_LIM);
  assign off_screen = (bx_min > bx_max) || (by_min > by_max);
  // Output slot is free when empty or being taken this cycle; also the DRAIN exit condition.
  assign adv        = !frag_valid_q || bus.frag_ready;
  assign last_pt    = (ptx_q == xmax_q) && (pty_q == ymax_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.tri_valid) state_d = SETUP;
      SETUP:   state_d = off_screen ? DRAIN : SCAN;
      SCAN:    if (adv && last_pt) state_d = DRAIN;
      DRAIN:   if (adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vx_d         = vx_q;
    vy_d         = vy_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymax_d       = ymax_q;
    ptx_d        = ptx_q;
    pty_d        = pty_q;
    frag_x_d     = frag_x_q;
    frag_y_d     = frag_y_q;
    frag_valid_d = frag_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tri_valid) begin
          vx_d = '{bus.v1x, bus.v2x, bus.v3x};
          vy_d = '{bus.v1y, bus.v2y, bus.v3y};
        end
      end
      SETUP: begin
        xmin_d = bx_min;
        xmax_d = bx_max;
        ymax_d = by_max;
        if (!off_screen) begin
          ptx_d = bx_min;
          pty_d = by_min;
        end
      end
      SCAN: begin
        if (adv) begin
          frag_valid_d = bus.test_inside;
          if (bus.test_inside) begin
            frag_x_d = ptx_q;
            frag_y_d = pty_q;
          end
          // The final point is held so the counters never pass xmax/ymax.
          if (ptx_q != xmax_q) begin
            ptx_d = ptx_q + 10'd1;
          end else if (pty_q != ymax_q) begin
            ptx_d = xmin_q;
            pty_d = pty_q + 10'd1;
          end
        end
      end
      DRAIN: begin
        if (adv) begin
          frag_valid_d = 1'b0;
          done_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_q         <= '{default: '0};
      vy_q         <= '{default: '0};
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymax_q       <= '0;
      ptx_q        <= '0;
      pty_q        <= '0;
      frag_x_q     <= '0;
      frag_y_q     <= '0;
      frag_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymax_q       <= ymax_d;
      ptx_q        <= ptx_d;
      pty_q        <= pty_d;
      frag_x_q     <= frag_x_d;
      frag_y_q     <= frag_y_d;
      frag_valid_q <= frag_valid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    bus.tri_ready = (state_q == IDLE);
  end

  assign bus.test_ptx   = ptx_q;
  assign bus.test_pty   = pty_q;
  assign bus.test_p1x   = vx_q[0];
  assign bus.test_p1y   = vy_q[0];
  assign bus.test_p2x   = vx_q[1];
  assign bus.test_p2y   = vy_q[1];
  assign bus.test_p3x   = vx_q[2];
  assign bus.test_p3y   = vy_q[2];
  assign bus.frag_valid = frag_valid_q;
  assign bus.frag_x     = frag_x_q;
  assign bus.frag_y     = frag_y_q;
  assign bus.done       = done_q;

`ifdef TRI_RASTER_STATS_EN
  logic [19:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && bus.tri_valid)   count_d = '0;
    else if (frag_valid_q && bus.frag_ready) count_d = count_q + 20'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.frag_count = count_q;
`endif
endmodule
